// File: rtl/dly_tap_ctrl_pkg.sv
// rtl/dly_tap_ctrl_pkg.sv - shared types and constants for the delay-tap sequencer
package dly_tap_ctrl_pkg;

    localparam int TAP_W    = 6;
    localparam int TAP_MAX  = 63;
    localparam int PULSE_HI = 2;
    localparam int PULSE_LO = 2;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        CMP,
        ADJ_HI,
        ADJ_LO,
        FIN
    } state_t;

endpackage

// File: rtl/dly_tap_ctrl_if.sv
// rtl/dly_tap_ctrl_if.sv - request, status and primitive-control bundle for dly_tap_ctrl
interface dly_tap_ctrl_if
    import dly_tap_ctrl_pkg::*;
();
    logic [TAP_W-1:0] TARGET_TAP;
    logic             TARGET_VALID;
    logic             TARGET_READY;
    logic             LOAD_REQ;
    logic [TAP_W-1:0] DLY_TAP_VALUE;
    logic             DLY_LOAD;
    logic             DLY_ADJ;
    logic             DLY_INCDEC;
    logic             BUSY;
    logic             DONE;
    logic             ERROR;
    logic [15:0]      ADJ_COUNT;

    modport slave (
        input  TARGET_TAP, TARGET_VALID, LOAD_REQ, DLY_TAP_VALUE,
        output TARGET_READY, DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, ADJ_COUNT
    );

    modport master (
        output TARGET_TAP, TARGET_VALID, LOAD_REQ, DLY_TAP_VALUE,
        input  TARGET_READY, DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR, ADJ_COUNT
    );

endinterface

// File: rtl/dly_pulse_gen.sv
// rtl/dly_pulse_gen.sv - fixed-width high/low pulse shared by load and adjust paths
module dly_pulse_gen
    import dly_tap_ctrl_pkg::*;
(
    input  logic CLK_IN,
    input  logic RST,
    input  logic start,
    output logic pulse,
    output logic hi_last,
    output logic done
);

    logic       active;
    logic [1:0] cnt;

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            active <= 1'b0;
            pulse  <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            pulse  <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (pulse) begin
                if (hi_last) begin
                    pulse <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end else if (done) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    // Both strobes mark the final cycle of their phase so the FSM moves on the same edge.
    assign hi_last = pulse && (cnt == 2'(PULSE_HI - 1));
    assign done    = active && !pulse && (cnt == 2'(PULSE_LO - 1));

endmodule

// File: rtl/dly_tap_ctrl.sv
// rtl/dly_tap_ctrl.sv - load/adjust sequencer for the input-delay primitive; DLY_TAP_CTRL_STATS_EN enables ADJ_COUNT
module dly_tap_ctrl
    import dly_tap_ctrl_pkg::*;
#(
    parameter int DELAY       = 0,
    parameter int STUCK_LIMIT = 2
) (
    input  logic           CLK_IN,
    input  logic           RST,
    dly_tap_ctrl_if.slave  bus
);

    state_t           state;
    logic [TAP_W-1:0] tgt;
    logic [TAP_W-1:0] prev;
    logic             dir;
    logic             err;
    logic [3:0]       stuck;
    logic [3:0]       stuck_nxt;
    logic             tap_hit;
    logic             pg_start;
    logic             pg_pulse;
    logic             pg_hi_last;
    logic             pg_done;

    assign tap_hit   = (bus.DLY_TAP_VALUE == tgt);
    assign stuck_nxt = stuck + 4'd1;
    assign pg_start  = ((state == IDLE) && bus.LOAD_REQ) || ((state == CMP) && !tap_hit);

    dly_pulse_gen u_pulse (
        .CLK_IN  (CLK_IN),
        .RST     (RST),
        .start   (pg_start),
        .pulse   (pg_pulse),
        .hi_last (pg_hi_last),
        .done    (pg_done)
    );

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            tgt   <= '0;
            prev  <= '0;
            dir   <= 1'b0;
            err   <= 1'b0;
            stuck <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.LOAD_REQ) begin
                        err   <= 1'b0;
                        stuck <= '0;
                        tgt   <= TAP_W'(DELAY);
                        state <= LD_HI;
                    end else if (bus.TARGET_VALID) begin
                        err   <= 1'b0;
                        stuck <= '0;
                        tgt   <= bus.TARGET_TAP;
                        state <= CMP;
                    end
                end
                LD_HI:  if (pg_hi_last) state <= LD_LO;
                LD_LO:  if (pg_done)    state <= FIN;
                CMP: begin
                    if (tap_hit) begin
                        state <= FIN;
                    end else begin
                        dir   <= (tgt > bus.DLY_TAP_VALUE);
                        prev  <= bus.DLY_TAP_VALUE;
                        state <= ADJ_HI;
                    end
                end
                ADJ_HI: if (pg_hi_last) state <= ADJ_LO;
                ADJ_LO: begin
                    // Tap has settled by now; an unchanged tap counts toward stuck detection.
                    if (pg_done) begin
                        if (bus.DLY_TAP_VALUE == prev) begin
                            stuck <= stuck_nxt;
                            if (stuck_nxt >= 4'(STUCK_LIMIT)) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= CMP;
                            end
                        end else begin
                            stuck <= '0;
                            state <= CMP;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TARGET_READY = (state == IDLE);
    assign bus.BUSY         = (state != IDLE);
    assign bus.DONE         = (state == FIN);
    assign bus.ERROR        = err;
    assign bus.DLY_INCDEC   = dir;
    assign bus.DLY_LOAD     = pg_pulse && (state == LD_HI);
    assign bus.DLY_ADJ      = pg_pulse && (state == ADJ_HI);

`ifdef DLY_TAP_CTRL_STATS_EN
    logic [15:0] adj_cnt;

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            adj_cnt <= '0;
        end else if ((state == CMP) && !tap_hit && (adj_cnt != 16'hFFFF)) begin
            adj_cnt <= adj_cnt + 16'd1;
        end
    end

    assign bus.ADJ_COUNT = adj_cnt;
`else
    assign bus.ADJ_COUNT = '0;
`endif

endmodule

// File: doc/dly_tap_ctrl.md
# dly_tap_ctrl

Sequencer that sits directly upstream of the input-delay primitive and drives its DLY_LOAD / DLY_ADJ / DLY_INCDEC control pins. It accepts a target tap value (0-63) over a valid/ready handshake, or a load request, and issues correctly spaced load/adjust pulses until the primitive's DLY_TAP_VALUE equals the target. The primitive double-registers and edge-detects its control inputs, so this block owns pulse width, spacing and direction stability.

## Interface
- DELAY, 0: tap value the primitive loads on DLY_LOAD; must equal the primitive's DELAY parameter; 0-63.
- STUCK_LIMIT, 2: consecutive adjust steps with no tap change before ERROR; 1-15.
- CLK_IN  input  1  clock; same clock as the primitive's CLK_IN.
- RST  input  1  reset, asynchronous, active-high.
- TARGET_TAP  input  6  requested tap value.
- TARGET_VALID  input  1  request valid.
- TARGET_READY  output  1  high only in IDLE.
- LOAD_REQ  input  1  load request, sampled only in IDLE; has priority over TARGET_VALID.
- DLY_TAP_VALUE  input  6  current tap from the primitive.
- DLY_LOAD  output  1  to primitive.
- DLY_ADJ  output  1  to primitive.
- DLY_INCDEC  output  1  to primitive; 1 = increment.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when a request completes successfully.
- ERROR  output  1  sticky; set on stuck detection; cleared when the next request is accepted.
- ADJ_COUNT  output  16  total adjust pulses issued (see Configuration).

## Operation
- States: IDLE, LD_HI, LD_LO, CMP, ADJ_HI, ADJ_LO, FIN.
- IDLE:
  - LOAD_REQ=1: go to LD_HI.
  - Otherwise, TARGET_VALID=1 (handshake TARGET_VALID & TARGET_READY): latch TARGET_TAP into tgt and go to CMP.
  - Accepting either request clears ERROR and zeroes the stuck counter.
- LD_HI: DLY_LOAD=1 for 2 cycles. LD_LO: DLY_LOAD=0 for 2 cycles, then FIN.
- CMP:
  - DLY_TAP_VALUE == tgt: go to FIN.
  - Otherwise, set dir = (tgt > DLY_TAP_VALUE), capture prev = DLY_TAP_VALUE, and go to ADJ_HI.
- ADJ_HI: DLY_ADJ=1 for 2 cycles. ADJ_LO: DLY_ADJ=0 for 2 cycles.
- Leaving ADJ_LO:
  - DLY_TAP_VALUE == prev: stuck counter +1. If it reaches STUCK_LIMIT, set ERROR and go to IDLE without DONE. Otherwise go to CMP.
  - Tap changed: zero the stuck counter and go to CMP.
- FIN: DONE=1 for one cycle, then IDLE.
- DLY_INCDEC holds dir from the CMP exit through the end of ADJ_LO. It is never changed while DLY_ADJ=1 or during the 2 cycles after DLY_ADJ falls.
- Only one of DLY_LOAD or DLY_ADJ is ever high.
- Tap comparisons are unsigned 6-bit. tgt is never modified mid-request. No wrap: an increment is never issued when the tap is 63, and a decrement is never issued when the tap is 0, because the direction derives from tgt ≠ tap.
- Requests arriving while BUSY are not accepted, since TARGET_READY=0. LOAD_REQ is ignored unless in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - DLY_LOAD=0, DLY_ADJ=0, DLY_INCDEC=0.
  - TARGET_READY=1, BUSY=0, DONE=0, ERROR=0, ADJ_COUNT=0.
  - tgt=0, prev=0, stuck counter=0.
- All outputs are registered, or decoded from registered state only.
- Target request already met: accept at edge 0, CMP at cycle 1, FIN at cycle 2 (DONE high), IDLE at cycle 3. Latency accept-to-DONE is 2 cycles.
- Each adjust step takes 5 cycles (CMP + 2×ADJ_HI + 2×ADJ_LO). For N steps, DONE is high in cycle 5N+2 after accept.
- Load: DONE is high 5 cycles after accept.
- The primitive's tap updates 2 edges after DLY_ADJ rises. It is stable before the ADJ_LO exit compare.
- RST asserted mid-operation immediately forces all reset values. DLY_ADJ and DLY_LOAD drop asynchronously. No DONE is generated.

## Configuration
- DLY_TAP_CTRL_STATS_EN defined: ADJ_COUNT increments by 1 on each ADJ_HI entry and saturates at 16'hFFFF. It is cleared only by RST.
- Not defined: ADJ_COUNT is tied to 0 and no counter is synthesized. All other behaviour is identical.

## Structure
- Package dly_tap_ctrl_pkg holds:
  - the state enum;
  - TAP_W=6 and TAP_MAX=63;
  - PULSE_HI=2 and PULSE_LO=2.
- Sub-module dly_pulse_gen: the start input produces an output that is high for PULSE_HI cycles and then low for PULSE_LO cycles, with a done strobe. It is instantiated once and shared by the load and adjust paths, selected by the FSM.

## Test plan
- Reset, then TARGET_TAP=0 with the primitive model at tap 0 → no DLY_ADJ pulse; DONE 2 cycles after accept; ADJ_COUNT=0.
- Tap 0, TARGET_TAP=5 → 5 DLY_ADJ pulses, DLY_INCDEC=1 throughout; DONE at cycle 27; tap reads 5; ADJ_COUNT=5 with the macro on, 0 with it off.
- Tap 63, TARGET_TAP=60 → 3 pulses, DLY_INCDEC=0 stable around every pulse; DONE at cycle 17.
- LOAD_REQ with DELAY=20 from tap 7 → one 2-cycle DLY_LOAD pulse; tap reads 20; DONE 5 cycles after accept. Asserting LOAD_REQ and TARGET_VALID together → the load wins and TARGET_READY drops.
- Primitive tap frozen at 10, TARGET_TAP=12, STUCK_LIMIT=2 → 2 pulses, then ERROR=1, IDLE, no DONE. The next accepted request clears ERROR.
- RST asserted during ADJ_HI of a 0→40 request → DLY_ADJ drops immediately and all outputs return to reset values. A new request after RST completes normally.
